// File: rtl/smbus_mailbox_pkg.sv
// Shared definitions for the SMBus mailbox: drain FSM states, word geometry,
// FIFO depth and a byte-lane insert helper used by the drain engine.
package smbus_mailbox_pkg;

   localparam int MAILBOX_WORD_BYTES = 4;
   localparam int MAILBOX_WORD_W     = 8 * MAILBOX_WORD_BYTES;
   localparam int MAILBOX_FIFO_DEPTH = 1023;

   typedef enum logic [2:0] {
      DRAIN_IDLE,
      DRAIN_READ,
      DRAIN_FLUSH,
      DRAIN_PRESENT,
      DRAIN_DONE
   } drain_state_e;

   // Writes one byte into the given little-endian lane of a word.
   function automatic logic [MAILBOX_WORD_W-1:0] insert_byte(
      input logic [MAILBOX_WORD_W-1:0] word,
      input logic [1:0]                lane,
      input logic [7:0]                data
   );
      logic [MAILBOX_WORD_W-1:0] r;
      r = word;
      r[8*lane +: 8] = data;
      return r;
   endfunction

endpackage

// File: rtl/mailbox_fifo_drain.sv
// Read-side drain engine for the mailbox byte FIFO. Dequeues byte_count
// bytes, packs them little-endian into 32-bit words and offers each word on
// a valid/ready stream. The FIFO has no empty flag, so the remaining byte
// count is tracked here and no dequeue is ever issued past it.
module mailbox_fifo_drain
   import smbus_mailbox_pkg::*;
#(
   parameter int BYTE_COUNT_WIDTH = 10
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [BYTE_COUNT_WIDTH-1:0] byte_count,
   input  logic                        abort,
   output logic                        busy,
   output logic                        done,
   output logic                        fifo_dequeue,
   input  logic [7:0]                  fifo_data,
   output logic [31:0]                 out_data,
   output logic                        out_valid,
   output logic                        out_last,
   input  logic                        out_ready
);

   localparam logic [1:0] LAST_LANE = 2'(MAILBOX_WORD_BYTES - 1);
   localparam logic [BYTE_COUNT_WIDTH-1:0] ONE_BYTE = BYTE_COUNT_WIDTH'(1);

   drain_state_e                state_q, state_d;
   logic [BYTE_COUNT_WIDTH-1:0] remaining_q, remaining_d;
   logic [1:0]                  lane_q, lane_d;
   logic                        cap_vld_q, cap_vld_d;
   logic [1:0]                  cap_lane_q, cap_lane_d;
   logic [MAILBOX_WORD_W-1:0]   word_q, word_d;

   assign out_data = word_q;

   // Next-state, counter, capture and output decode; abort/reset override all.
   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      lane_d       = lane_q;
      cap_vld_d    = 1'b0;
      cap_lane_d   = cap_lane_q;
      word_d       = word_q;
      busy         = 1'b0;
      done         = 1'b0;
      fifo_dequeue = 1'b0;
      out_valid    = 1'b0;
      out_last     = 1'b0;

      // A byte dequeued last cycle is on fifo_data now; drop it into its lane.
      if (cap_vld_q) begin
         word_d = insert_byte(word_q, cap_lane_q, fifo_data);
      end

      case (state_q)
         DRAIN_IDLE: begin
            if (start) begin
               if (byte_count != '0) begin
                  state_d     = DRAIN_READ;
                  remaining_d = byte_count;
                  lane_d      = '0;
                  word_d      = '0;
               end else begin
                  state_d     = DRAIN_DONE;
                  remaining_d = '0;
               end
            end
         end

         DRAIN_READ: begin
            busy = 1'b1;
            if (remaining_q != '0) begin
               fifo_dequeue = 1'b1;
               cap_vld_d    = 1'b1;
               cap_lane_d   = lane_q;
               lane_d       = lane_q + 2'd1;
               remaining_d  = remaining_q - ONE_BYTE;
            end
            // Leave after the fourth lane or the last byte of the transfer.
            if (lane_q == LAST_LANE || remaining_q <= ONE_BYTE) begin
               state_d = DRAIN_FLUSH;
            end
         end

         DRAIN_FLUSH: begin
            busy    = 1'b1;
            lane_d  = '0;
            state_d = DRAIN_PRESENT;
         end

         DRAIN_PRESENT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_last  = (remaining_q == '0);
            if (out_ready) begin
               word_d = '0;
               lane_d = '0;
               if (remaining_q != '0) begin
                  state_d = DRAIN_READ;
               end else begin
                  state_d = DRAIN_DONE;
               end
            end
         end

         DRAIN_DONE: begin
            done    = 1'b1;
            state_d = DRAIN_IDLE;
         end

         default: begin
            state_d = DRAIN_IDLE;
         end
      endcase

      // Abort/reset: stop touching the FIFO this cycle, drop any in-flight
      // byte and return everything to the idle values next cycle.
      if (abort || reset) begin
         state_d      = DRAIN_IDLE;
         remaining_d  = '0;
         lane_d       = '0;
         cap_vld_d    = 1'b0;
         cap_lane_d   = '0;
         word_d       = '0;
         fifo_dequeue = 1'b0;
         out_valid    = 1'b0;
         out_last     = 1'b0;
      end
   end

   // State, counters and word register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= DRAIN_IDLE;
         remaining_q <= '0;
         lane_q      <= '0;
         cap_vld_q   <= 1'b0;
         cap_lane_q  <= '0;
         word_q      <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         lane_q      <= lane_d;
         cap_vld_q   <= cap_vld_d;
         cap_lane_q  <= cap_lane_d;
         word_q      <= word_d;
      end
   end

endmodule

// File: tb/tb_mailbox_fifo_drain.sv
// Directed bench for mailbox_fifo_drain with a behavioural byte FIFO that
// returns data the cycle after a dequeue and 0 when empty.
module tb_mailbox_fifo_drain;

   localparam int BCW = 10;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic [BCW-1:0] byte_count;
   logic           abort;
   logic           busy;
   logic           done;
   logic           fifo_dequeue;
   logic [7:0]     fifo_data = 8'h00;
   logic [31:0]    out_data;
   logic           out_valid;
   logic           out_last;
   logic           out_ready;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0]  fifo_q[$];
   logic        deq_pend = 1'b0;

   logic [31:0] words[$];
   logic        lasts[$];
   int          wcyc[$];
   int          deq_cnt    = 0;
   int          done_cnt   = 0;
   int          done_cyc   = 0;
   int          valid_seen = 0;

   mailbox_fifo_drain #(.BYTE_COUNT_WIDTH(BCW)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .byte_count   (byte_count),
      .abort        (abort),
      .busy         (busy),
      .done         (done),
      .fifo_dequeue (fifo_dequeue),
      .fifo_data    (fifo_data),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_last     (out_last),
      .out_ready    (out_ready)
   );

   always #5 clk = ~clk;

   // Cycle counter and FIFO read port model.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (deq_pend) begin
         if (fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
         else                   fifo_data <= 8'h00;
      end
   end

   // Monitor sampled mid-cycle.
   always @(negedge clk) begin
      deq_pend <= fifo_dequeue;
      if (fifo_dequeue) deq_cnt <= deq_cnt + 1;
      if (out_valid) valid_seen <= valid_seen + 1;
      if (out_valid && out_ready) begin
         words.push_back(out_data);
         lasts.push_back(out_last);
         wcyc.push_back(cyc);
      end
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int budget, input int base, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done_cnt > base) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic load_bytes(input int n, input logic [7:0] first);
      fifo_q.delete();
      for (int i = 0; i < n; i++) fifo_q.push_back(first + 8'(i));
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0; byte_count = '0;
      step(); step();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (fifo_dequeue !== 1'b0) begin bad++; $display("FAIL reset_deq got=%b want=0", fifo_dequeue); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
      total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", out_last); end
      total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=00000000", out_data); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_full_word();
      int t0, db, wb, qb;
      bit ok;
      fifo_q.delete();
      fifo_q.push_back(8'h11); fifo_q.push_back(8'h22);
      fifo_q.push_back(8'h33); fifo_q.push_back(8'h44);
      out_ready = 1'b1;
      db = done_cnt; wb = words.size(); qb = deq_cnt;
      start = 1'b1; byte_count = 10'd4; t0 = cyc;
      step(); start = 1'b0;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL full_busy_c1 got=%b want=1", busy); end
      wait_done(40, db, ok);
      total++; if (!ok) begin bad++; $display("FAIL full_timeout got=no_done want=done"); end
      step(); step();
      total++; if (words.size() - wb !== 1) begin bad++; $display("FAIL full_nwords got=%0d want=1", words.size() - wb); end
      if (words.size() > wb) begin
         total++; if (words[wb] !== 32'h44332211) begin bad++; $display("FAIL full_data got=%h want=44332211", words[wb]); end
         total++; if (lasts[wb] !== 1'b1) begin bad++; $display("FAIL full_last got=%b want=1", lasts[wb]); end
         total++; if (wcyc[wb] - t0 !== 6) begin bad++; $display("FAIL full_valid_cycle got=%0d want=6", wcyc[wb] - t0); end
      end
      total++; if (done_cyc - t0 !== 7) begin bad++; $display("FAIL full_done_cycle got=%0d want=7", done_cyc - t0); end
      total++; if (deq_cnt - qb !== 4) begin bad++; $display("FAIL full_deq got=%0d want=4", deq_cnt - qb); end
      total++; if (done_cnt - db !== 1) begin bad++; $display("FAIL full_done_cnt got=%0d want=1", done_cnt - db); end
   endtask

   task automatic test_partial_word();
      int t0, db, wb, qb;
      bit ok;
      load_bytes(6, 8'h01);
      out_ready = 1'b1;
      db = done_cnt; wb = words.size(); qb = deq_cnt;
      start = 1'b1; byte_count = 10'd6; t0 = cyc;
      step(); start = 1'b0;
      wait_done(60, db, ok);
      total++; if (!ok) begin bad++; $display("FAIL part_timeout got=no_done want=done"); end
      step(); step();
      total++; if (words.size() - wb !== 2) begin bad++; $display("FAIL part_nwords got=%0d want=2", words.size() - wb); end
      if (words.size() >= wb + 2) begin
         total++; if (words[wb] !== 32'h04030201) begin bad++; $display("FAIL part_w0 got=%h want=04030201", words[wb]); end
         total++; if (lasts[wb] !== 1'b0) begin bad++; $display("FAIL part_last0 got=%b want=0", lasts[wb]); end
         total++; if (words[wb+1] !== 32'h00000605) begin bad++; $display("FAIL part_w1 got=%h want=00000605", words[wb+1]); end
         total++; if (lasts[wb+1] !== 1'b1) begin bad++; $display("FAIL part_last1 got=%b want=1", lasts[wb+1]); end
         total++; if (wcyc[wb+1] - t0 !== 10) begin bad++; $display("FAIL part_w1_cycle got=%0d want=10", wcyc[wb+1] - t0); end
      end
      total++; if (done_cyc - t0 !== 11) begin bad++; $display("FAIL part_done_cycle got=%0d want=11", done_cyc - t0); end
      total++; if (deq_cnt - qb !== 6) begin bad++; $display("FAIL part_deq got=%0d want=6", deq_cnt - qb); end
   endtask

   task automatic test_backpressure();
      int t0, db, wb, qb, i;
      bit ok;
      load_bytes(8, 8'hA0);
      out_ready = 1'b0;
      db = done_cnt; wb = words.size(); qb = deq_cnt;
      start = 1'b1; byte_count = 10'd8; t0 = cyc;
      step(); start = 1'b0;
      for (i = 0; i < 20; i++) begin
         if (out_valid) break;
         step();
      end
      total++; if (cyc - t0 !== 6) begin bad++; $display("FAIL bp_valid_cycle got=%0d want=6", cyc - t0); end
      for (int k = 0; k < 10; k++) begin
         total++; if (out_data !== 32'hA3A2A1A0 || out_valid !== 1'b1) begin
            bad++; $display("FAIL bp_stall_hold got=%h/%b want=a3a2a1a0/1", out_data, out_valid);
         end
         step();
      end
      total++; if (deq_cnt - qb !== 4) begin bad++; $display("FAIL bp_stall_deq got=%0d want=4", deq_cnt - qb); end
      out_ready = 1'b1;
      wait_done(40, db, ok);
      total++; if (!ok) begin bad++; $display("FAIL bp_timeout got=no_done want=done"); end
      step(); step();
      total++; if (words.size() - wb !== 2) begin bad++; $display("FAIL bp_nwords got=%0d want=2", words.size() - wb); end
      if (words.size() >= wb + 2) begin
         total++; if (words[wb] !== 32'hA3A2A1A0) begin bad++; $display("FAIL bp_w0 got=%h want=a3a2a1a0", words[wb]); end
         total++; if (words[wb+1] !== 32'hA7A6A5A4) begin bad++; $display("FAIL bp_w1 got=%h want=a7a6a5a4", words[wb+1]); end
         total++; if (lasts[wb+1] !== 1'b1) begin bad++; $display("FAIL bp_last1 got=%b want=1", lasts[wb+1]); end
      end
      total++; if (deq_cnt - qb !== 8) begin bad++; $display("FAIL bp_deq got=%0d want=8", deq_cnt - qb); end
   endtask

   task automatic test_zero_count();
      int t0, db, vb, qb, wb;
      bit ok;
      fifo_q.delete();
      fifo_q.push_back(8'hEE);
      out_ready = 1'b1;
      db = done_cnt; vb = valid_seen; qb = deq_cnt; wb = words.size();
      start = 1'b1; byte_count = 10'd0; t0 = cyc;
      step(); start = 1'b0;
      total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL zero_done_c1 got=%b/%b want=1/0", done, busy); end
      wait_done(10, db, ok);
      step(); step(); step();
      total++; if (done_cyc - t0 !== 1) begin bad++; $display("FAIL zero_done_cycle got=%0d want=1", done_cyc - t0); end
      total++; if (valid_seen - vb !== 0) begin bad++; $display("FAIL zero_valid got=%0d want=0", valid_seen - vb); end
      total++; if (deq_cnt - qb !== 0) begin bad++; $display("FAIL zero_deq got=%0d want=0", deq_cnt - qb); end
      total++; if (words.size() - wb !== 0) begin bad++; $display("FAIL zero_words got=%0d want=0", words.size() - wb); end
   endtask

   task automatic test_abort();
      int t0, db, vb, qb, wb;
      bit ok;
      load_bytes(8, 8'h30);
      out_ready = 1'b1;
      db = done_cnt; vb = valid_seen; qb = deq_cnt;
      start = 1'b1; byte_count = 10'd8; t0 = cyc;
      step(); start = 1'b0;
      step(); step();
      abort = 1'b1;
      step(); abort = 1'b0;
      total++; if (busy !== 1'b0 || out_valid !== 1'b0 || fifo_dequeue !== 1'b0 || out_data !== 32'h0) begin
         bad++; $display("FAIL abort_idle got=%b/%b/%b/%h want=0/0/0/00000000", busy, out_valid, fifo_dequeue, out_data);
      end
      repeat (8) step();
      total++; if (deq_cnt - qb !== 2) begin bad++; $display("FAIL abort_deq got=%0d want=2", deq_cnt - qb); end
      total++; if (done_cnt - db !== 0) begin bad++; $display("FAIL abort_done got=%0d want=0", done_cnt - db); end
      total++; if (valid_seen - vb !== 0) begin bad++; $display("FAIL abort_valid got=%0d want=0", valid_seen - vb); end
      // Fresh transfer after the abort.
      load_bytes(4, 8'h5A);
      db = done_cnt; wb = words.size(); qb = deq_cnt;
      start = 1'b1; byte_count = 10'd4; t0 = cyc;
      step(); start = 1'b0;
      wait_done(40, db, ok);
      total++; if (!ok) begin bad++; $display("FAIL abort_restart_timeout got=no_done want=done"); end
      step(); step();
      total++; if (words.size() - wb !== 1) begin bad++; $display("FAIL abort_restart_nwords got=%0d want=1", words.size() - wb); end
      if (words.size() > wb) begin
         total++; if (words[wb] !== 32'h5D5C5B5A) begin bad++; $display("FAIL abort_restart_data got=%h want=5d5c5b5a", words[wb]); end
      end
      total++; if (deq_cnt - qb !== 4) begin bad++; $display("FAIL abort_restart_deq got=%0d want=4", deq_cnt - qb); end
   endtask

   task automatic test_start_while_busy();
      int t0, db, wb, qb, i;
      bit ok;
      load_bytes(8, 8'hC0);
      out_ready = 1'b0;
      db = done_cnt; wb = words.size(); qb = deq_cnt;
      start = 1'b1; byte_count = 10'd4; t0 = cyc;
      step(); start = 1'b0;
      for (i = 0; i < 20; i++) begin
         if (out_valid) break;
         step();
      end
      start = 1'b1; byte_count = 10'd8;
      step(); start = 1'b0; byte_count = 10'd0;
      total++; if (out_data !== 32'hC3C2C1C0 || out_valid !== 1'b1) begin
         bad++; $display("FAIL busy_start_hold got=%h/%b want=c3c2c1c0/1", out_data, out_valid);
      end
      step();
      out_ready = 1'b1;
      wait_done(40, db, ok);
      total++; if (!ok) begin bad++; $display("FAIL busy_start_timeout got=no_done want=done"); end
      repeat (6) step();
      total++; if (words.size() - wb !== 1) begin bad++; $display("FAIL busy_start_nwords got=%0d want=1", words.size() - wb); end
      if (words.size() > wb) begin
         total++; if (words[wb] !== 32'hC3C2C1C0) begin bad++; $display("FAIL busy_start_data got=%h want=c3c2c1c0", words[wb]); end
         total++; if (lasts[wb] !== 1'b1) begin bad++; $display("FAIL busy_start_last got=%b want=1", lasts[wb]); end
      end
      total++; if (deq_cnt - qb !== 4) begin bad++; $display("FAIL busy_start_deq got=%0d want=4", deq_cnt - qb); end
   endtask

   task automatic test_reset_mid();
      int db;
      load_bytes(8, 8'h70);
      out_ready = 1'b1;
      db = done_cnt;
      start = 1'b1; byte_count = 10'd8;
      step(); start = 1'b0;
      step(); step();
      reset = 1'b1;
      step(); reset = 1'b0;
      total++; if (busy !== 1'b0 || done !== 1'b0 || fifo_dequeue !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
         bad++; $display("FAIL rst_mid_ctrl got=%b%b%b%b%b want=00000", busy, done, fifo_dequeue, out_valid, out_last);
      end
      total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_mid_data got=%h want=00000000", out_data); end
      repeat (5) step();
      total++; if (done_cnt - db !== 0) begin bad++; $display("FAIL rst_mid_done got=%0d want=0", done_cnt - db); end
   endtask

   initial begin
      test_reset();
      test_full_word();
      test_partial_word();
      test_backpressure();
      test_zero_count();
      test_abort();
      test_start_while_busy();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mailbox_fifo_drain.md
# mailbox_fifo_drain

Read-side engine for the SMBus mailbox byte FIFO. On a start pulse it dequeues a given number of bytes from the FIFO, packs them little-endian into 32-bit words and presents each word on a valid/ready stream toward the Nios/crypto datapath. It sits between the mailbox FIFO's `dequeue`/`data_out` pins and the word consumer. It tracks the byte count itself because the FIFO exposes no empty flag and returns 0 when empty.

## Interface
- `BYTE_COUNT_WIDTH`, default 10: width of the byte count; max transfer 2^W-1 bytes, matching the 1023-deep FIFO.
- `clk`  in  1: single clock, shared with the FIFO.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: single-cycle request; latches `byte_count`. Ignored while `busy`.
- `byte_count`  in  BYTE_COUNT_WIDTH: number of bytes to drain.
- `abort`  in  1: cancels the transfer; FIFO contents are not touched further.
- `busy`  out  1: high from the cycle after an accepted `start` until `done`/abort.
- `done`  out  1: one-cycle pulse when a transfer completes normally.
- `fifo_dequeue`  out  1: drives the FIFO `dequeue`.
- `fifo_data`  in  8: the FIFO `data_out`; valid the cycle after `fifo_dequeue`.
- `out_data`  out  32: packed word; first byte in [7:0].
- `out_valid`  out  1: word available.
- `out_last`  out  1: qualifies the final word of a transfer.
- `out_ready`  in  1: consumer accepts when high with `out_valid`.

## Operation
- States:
  - IDLE → READ on accepted `start` with `byte_count` > 0.
  - IDLE → DONE on `start` with `byte_count` = 0.
  - READ → FLUSH after the last dequeue of the word.
  - FLUSH → PRESENT.
  - PRESENT → READ on handshake if bytes remain; PRESENT → DONE on handshake if none remain.
  - DONE → IDLE unconditionally.
- READ:
  - `fifo_dequeue` is high every cycle for n = min(4, remaining) cycles.
  - `remaining` decrements per dequeue.
  - A lane index 0..3 increments per dequeue.
- Capture: the byte for lane k is written into `out_data[8k+7:8k]` the cycle after its dequeue. FLUSH captures the final byte of the word.
- Word register is cleared to 0 on entry to READ, so unused upper lanes of a partial last word read 0.
- PRESENT:
  - `out_valid` = 1.
  - `out_data` and `out_last` are held stable until `out_ready`; no dequeue is issued while waiting.
  - `out_last` = (remaining == 0).
- DONE: `done` = 1 for exactly one cycle; `busy` = 0 in that cycle.
- `abort` (any state): next cycle is IDLE, all outputs low, no `done`. The abort takes effect even during the cycle a byte is still in flight from the FIFO; that byte is dropped.
- `abort` and `start` in the same cycle: abort wins.
- `reset` behaves identically to `abort`: state IDLE, counters 0.
- `remaining` arithmetic: unsigned, BYTE_COUNT_WIDTH bits, never decremented below 0.
- Lane index: 2 bits; wraps to 0 at each word.

## Timing
- Reset values: `busy`, `done`, `fifo_dequeue`, `out_valid`, `out_last` = 0; `out_data` = 0.
- Example: `start` sampled at cycle 0.
  - Dequeues in cycles 1–4; captures in cycles 2–5 (cycle 5 = FLUSH).
  - `out_valid` rises at cycle 6.
- Full words with `out_ready` tied high: one word per 6 cycles.
- Final handshake at cycle t → `done` at t+1 → IDLE at t+2; a new `start` is accepted at t+2.
- `byte_count` = 0: `done` the cycle after `start`; no dequeue, no output.
- `fifo_dequeue` never asserts more than `byte_count` times per transfer.

## Structure
- Shared package `smbus_mailbox_pkg` holds:
  - the drain state enum (IDLE, READ, FLUSH, PRESENT, DONE);
  - `MAILBOX_WORD_BYTES` = 4;
  - `MAILBOX_FIFO_DEPTH` = 1023, shared with the FIFO instance.
- No sub-module; a single FSM plus counters. The FIFO is instantiated by the parent mailbox, not inside this block.

## Test plan
- Full word: FIFO holds 0x11,0x22,0x33,0x44; `start`, count = 4, `out_ready` = 1 → one word 0x44332211 with `out_last` = 1 at cycle 6; `done` at cycle 7; exactly 4 dequeues.
- Partial word: 6 bytes 0x01..0x06 → words 0x04030201 (`out_last` = 0), then 0x00000605 (`out_last` = 1); 6 dequeues total.
- Backpressure: count = 8, `out_ready` low for 10 cycles on the first word → `out_data` stable; no dequeue during the stall; second word follows the handshake; `done` after the second word.
- Zero count: `start` with count = 0 → `done` at cycle 1; `out_valid` and `fifo_dequeue` never assert.
- Abort mid-READ: count = 8, `abort` at cycle 3 → IDLE at cycle 4; no `out_valid`, no `done`; 2 dequeues observed; a new `start` is then accepted and operates normally.
- `start` while busy: second `start` during PRESENT → ignored; byte count and output words unchanged. `reset` asserted mid-transfer → all outputs 0 next cycle.
